// File: rtl/pll_mgmt_pkg.sv
`default_nettype none
// ============================================================================
// Module : pll_mgmt_pkg
// Brief  : Shared address map, FSM state type and STATUS bit positions for
//          the PLL reconfiguration management responder.
// Rev    : 1.0  initial release
// ============================================================================
package pll_mgmt_pkg;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;

   // Register address map
   localparam logic [ADDR_W-1:0] ADDR_MODE   = 6'd0;
   localparam logic [ADDR_W-1:0] ADDR_STATUS = 6'd1;
   localparam logic [ADDR_W-1:0] ADDR_START  = 6'd2;
   localparam logic [ADDR_W-1:0] ADDR_M      = 6'd4;
   localparam logic [ADDR_W-1:0] ADDR_K      = 6'd7;

   // STATUS register bit positions
   localparam int STATUS_IDLE_BIT = 0;
   localparam int STATUS_ERR_BIT  = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      LOCK = 2'd2
   } pll_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pll_mgmt_if.sv
`default_nettype none
// ============================================================================
// Module : pll_mgmt_if
// Brief  : PLL management bus (address/read/write with waitrequest stall).
//          master = sequencer side, slave = responder side.
// Rev    : 1.0  initial release
// ============================================================================
interface pll_mgmt_if;

   logic [5:0]  mgmt_address;
   logic        mgmt_write;
   logic [31:0] mgmt_writedata;
   logic        mgmt_read;
   logic [31:0] mgmt_readdata;
   logic        mgmt_waitrequest;

   modport master (
      output mgmt_address, mgmt_write, mgmt_writedata, mgmt_read,
      input  mgmt_readdata, mgmt_waitrequest
   );

   modport slave (
      input  mgmt_address, mgmt_write, mgmt_writedata, mgmt_read,
      output mgmt_readdata, mgmt_waitrequest
   );

endinterface
`default_nettype wire

// File: rtl/pll_mgmt_regbank.sv
`default_nettype none
// ============================================================================
// Module : pll_mgmt_regbank
// Brief  : Staged and active M/K registers, MODE bit, sticky error flag and
//          registered read-data mux. Staged values move to active on commit.
// Rev    : 1.0  initial release
// ============================================================================
module pll_mgmt_regbank
   import pll_mgmt_pkg::*;
#(
   parameter logic [31:0] K_DEFAULT = 32'd3639383488,
   parameter logic [31:0] M_DEFAULT = 32'h0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,      // accepted write that takes effect
   input  logic              wr_drop,    // accepted write discarded during BUSY
   input  logic              rd_en,      // accepted read
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] writedata,
   input  logic              commit,     // staged -> active strobe
   input  logic              is_idle,
   output logic              mode,
   output logic [DATA_W-1:0] readdata,
   output logic [DATA_W-1:0] k_active,
   output logic [DATA_W-1:0] m_active
);

   logic              r_mode;
   logic              r_err;
   logic [DATA_W-1:0] r_k_staged;
   logic [DATA_W-1:0] r_m_staged;
   logic [DATA_W-1:0] r_k_active;
   logic [DATA_W-1:0] r_m_active;
   logic [DATA_W-1:0] r_readdata;
   logic [DATA_W-1:0] w_rd_mux;

   // Register writes; a dropped write flags the sticky error, MODE writes clear it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mode     <= 1'b0;
         r_err      <= 1'b0;
         r_k_staged <= K_DEFAULT;
         r_m_staged <= M_DEFAULT;
      end else if (wr_drop) begin
         r_err <= 1'b1;
      end else if (wr_en) begin
         case (address)
            ADDR_MODE: begin
               r_mode <= writedata[0];
               r_err  <= 1'b0;
            end
            ADDR_M:  r_m_staged <= writedata;
            ADDR_K:  r_k_staged <= writedata;
            default: ;
         endcase
      end
   end

   // Active values follow staged values only on a commit strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_k_active <= K_DEFAULT;
         r_m_active <= M_DEFAULT;
      end else if (commit) begin
         r_k_active <= r_k_staged;
         r_m_active <= r_m_staged;
      end
   end

   // Read mux: unmapped and write-only addresses read as zero
   always_comb begin
      w_rd_mux = '0;
      case (address)
         ADDR_MODE:   w_rd_mux[0] = r_mode;
         ADDR_STATUS: begin
            w_rd_mux[STATUS_IDLE_BIT] = is_idle;
            w_rd_mux[STATUS_ERR_BIT]  = r_err;
         end
         ADDR_M:      w_rd_mux = r_m_staged;
         ADDR_K:      w_rd_mux = r_k_staged;
         default:     ;
      endcase
   end

   // Read data is captured on an accepted read and held until the next one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_readdata <= '0;
      end else if (rd_en) begin
         r_readdata <= w_rd_mux;
      end
   end

   assign mode     = r_mode;
   assign readdata = r_readdata;
   assign k_active = r_k_active;
   assign m_active = r_m_active;

endmodule
`default_nettype wire

// File: rtl/pll_mgmt_responder.sv
`default_nettype none
// ============================================================================
// Module : pll_mgmt_responder
// Brief  : Responder end of the PLL reconfiguration management bus. Stages
//          M/K writes, commits them after a START, then models the relock.
// Rev    : 1.0  initial release
// ============================================================================
module pll_mgmt_responder
   import pll_mgmt_pkg::*;
#(
   parameter int          RECONFIG_CYCLES = 16,
   parameter int          LOCK_CYCLES     = 64,
   parameter logic [31:0] K_DEFAULT       = 32'd3639383488,
   parameter logic [31:0] M_DEFAULT       = 32'h0
) (
   input  logic        mgmt_clk,
   input  logic        mgmt_reset,
   pll_mgmt_if.slave   mgmt,
   output logic [31:0] k_active,
   output logic [31:0] m_active,
   output logic        pll_locked,
   output logic        reconfig_done
);

   localparam int CNT_W = $clog2(max_int(RECONFIG_CYCLES, LOCK_CYCLES) + 1);
   localparam logic [CNT_W-1:0] C_RECONFIG_LOAD = CNT_W'(RECONFIG_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_LOCK_LOAD     = CNT_W'(LOCK_CYCLES - 1);

   pll_state_t        r_state;
   logic [CNT_W-1:0]  r_count;
   logic              r_locked;
   logic              r_done;

   logic              w_mode;
   logic              w_waitrequest;
   logic              w_wr_acc;
   logic              w_rd_acc;
   logic              w_wr_eff;
   logic              w_wr_drop;
   logic              w_start;
   logic              w_commit;

   // Stall only depends on registered state, never on the request inputs
   assign w_waitrequest = !w_mode && (r_state == BUSY);

   // Write beats read on a shared cycle; writes during BUSY (polling mode) are dropped
   assign w_wr_acc  = mgmt.mgmt_write && !w_waitrequest;
   assign w_rd_acc  = mgmt.mgmt_read && !mgmt.mgmt_write && !w_waitrequest;
   assign w_wr_drop = w_wr_acc && (r_state == BUSY);
   assign w_wr_eff  = w_wr_acc && (r_state != BUSY);
   assign w_start   = w_wr_eff && (mgmt.mgmt_address == ADDR_START);
   assign w_commit  = (r_state == BUSY) && (r_count == '0);

   // Reconfig sequencer: IDLE -> BUSY on START, commit at end of BUSY, relock in LOCK.
   // The counter is preloaded with the lock time on reset so that the post-reset
   // relock lasts the same LOCK_CYCLES as a post-commit relock.
   always_ff @(posedge mgmt_clk or posedge mgmt_reset) begin
      if (mgmt_reset) begin
         r_state  <= LOCK;
         r_count  <= C_LOCK_LOAD;
         r_locked <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_state <= BUSY;
                  r_count <= C_RECONFIG_LOAD;
               end
            end
            BUSY: begin
               if (r_count == '0) begin
                  r_state  <= LOCK;
                  r_count  <= C_LOCK_LOAD;
                  r_locked <= 1'b0;
                  r_done   <= 1'b1;
               end else begin
                  r_count <= r_count - CNT_W'(1);
               end
            end
            LOCK: begin
               if (w_start) begin
                  r_state <= BUSY;
                  r_count <= C_RECONFIG_LOAD;
               end else if (r_count == '0) begin
                  r_state  <= IDLE;
                  r_locked <= 1'b1;
               end else begin
                  r_count <= r_count - CNT_W'(1);
               end
            end
            default: begin
               r_state  <= LOCK;
               r_count  <= C_LOCK_LOAD;
               r_locked <= 1'b0;
            end
         endcase
      end
   end

   pll_mgmt_regbank #(
      .K_DEFAULT (K_DEFAULT),
      .M_DEFAULT (M_DEFAULT)
   ) u_regbank (
      .clk       (mgmt_clk),
      .rst       (mgmt_reset),
      .wr_en     (w_wr_eff),
      .wr_drop   (w_wr_drop),
      .rd_en     (w_rd_acc),
      .address   (mgmt.mgmt_address),
      .writedata (mgmt.mgmt_writedata),
      .commit    (w_commit),
      .is_idle   (r_state == IDLE),
      .mode      (w_mode),
      .readdata  (mgmt.mgmt_readdata),
      .k_active  (k_active),
      .m_active  (m_active)
   );

   assign mgmt.mgmt_waitrequest = w_waitrequest;
   assign pll_locked            = r_locked;
   assign reconfig_done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pll_mgmt_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_pll_mgmt_responder
// Brief  : Directed self-checking bench for pll_mgmt_responder.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pll_mgmt_responder;
   import pll_mgmt_pkg::*;

   localparam logic [31:0] K_DEF = 32'd3639383488;
   localparam logic [31:0] K_NEW = 32'd3262113561;

   logic        mgmt_clk   = 1'b0;
   logic        mgmt_reset = 1'b1;
   logic [31:0] k_active;
   logic [31:0] m_active;
   logic        pll_locked;
   logic        reconfig_done;

   int n_tests = 0;
   int n_fail  = 0;

   pll_mgmt_if bus ();

   pll_mgmt_responder #(
      .RECONFIG_CYCLES (16),
      .LOCK_CYCLES     (64),
      .K_DEFAULT       (K_DEF),
      .M_DEFAULT       (32'h0)
   ) dut (
      .mgmt_clk      (mgmt_clk),
      .mgmt_reset    (mgmt_reset),
      .mgmt          (bus),
      .k_active      (k_active),
      .m_active      (m_active),
      .pll_locked    (pll_locked),
      .reconfig_done (reconfig_done)
   );

   // 50 MHz management clock
   always #10 mgmt_clk = ~mgmt_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge mgmt_clk);
      #1;
   endtask

   task automatic bus_write(input logic [5:0] a, input logic [31:0] d, output int stalls);
      logic w;
      logic acc;
      acc    = 1'b0;
      stalls = 0;
      bus.mgmt_address   = a;
      bus.mgmt_writedata = d;
      bus.mgmt_write     = 1'b1;
      for (int i = 0; i < 200; i++) begin
         w = bus.mgmt_waitrequest;
         tick();
         if (!w) begin
            acc = 1'b1;
            break;
         end
         stalls++;
      end
      bus.mgmt_write = 1'b0;
      if (!acc) check("write_timeout", 32'd0, 32'd1);
   endtask

   task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
      logic w;
      logic acc;
      acc = 1'b0;
      bus.mgmt_address = a;
      bus.mgmt_read    = 1'b1;
      for (int i = 0; i < 200; i++) begin
         w = bus.mgmt_waitrequest;
         tick();
         if (!w) begin
            acc = 1'b1;
            break;
         end
      end
      bus.mgmt_read = 1'b0;
      d = bus.mgmt_readdata;
      if (!acc) check("read_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_locked();
      logic got;
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (pll_locked) begin
            got = 1'b1;
            break;
         end
         tick();
      end
      if (!got) check("wait_locked_timeout", 32'd0, 32'd1);
   endtask

   // Absolute stop in case something wedges outside the bounded tasks
   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          st;
      int          lo;
      int          wr_hi;
      int          dn;
      logic [31:0] rd;
      logic        seen;

      bus.mgmt_address   = '0;
      bus.mgmt_write     = 1'b0;
      bus.mgmt_writedata = '0;
      bus.mgmt_read      = 1'b0;

      // ---- 1: reset state and post-reset relock --------------------------
      tick(); tick(); tick();
      check("rst_locked",   {31'b0, pll_locked},            32'd0);
      check("rst_done",     {31'b0, reconfig_done},         32'd0);
      check("rst_wait",     {31'b0, bus.mgmt_waitrequest},  32'd0);
      check("rst_readdata", bus.mgmt_readdata,              32'd0);
      check("rst_k_active", k_active,                       K_DEF);
      check("rst_m_active", m_active,                       32'd0);
      mgmt_reset = 1'b0;
      lo = 0;
      for (int i = 0; i < 100; i++) begin
         if (!pll_locked) lo++;
         tick();
      end
      check("t1_locked_low_cycles", lo, 32'd64);
      check("t1_locked_high",       {31'b0, pll_locked}, 32'd1);
      check("t1_k_active",          k_active, K_DEF);

      // ---- 2: sequencer order MODE, K, START ----------------------------
      bus_write(ADDR_MODE, 32'd0, st);
      bus_write(ADDR_K, K_NEW, st);
      bus_write(ADDR_START, 32'd0, st);
      wr_hi = 0; dn = 0; lo = 0;
      for (int i = 0; i < 120; i++) begin
         if (bus.mgmt_waitrequest) wr_hi++;
         if (reconfig_done)        dn++;
         if (!pll_locked)          lo++;
         if (i == 0)  check("t2_k_before_commit", k_active, K_DEF);
         if (i == 16) check("t2_k_at_done",       k_active, K_NEW);
         tick();
      end
      check("t2_wait_cycles",   wr_hi, 32'd16);
      check("t2_done_pulses",   dn,    32'd1);
      check("t2_locked_low",    lo,    32'd64);
      check("t2_k_active",      k_active, K_NEW);

      // ---- 3: write held through BUSY in waitrequest mode ---------------
      bus_write(ADDR_START, 32'd0, st);
      bus_write(ADDR_K, 32'd5, st);
      check("t3_stall_cycles", st, 32'd16);
      check("t3_k_active_unchanged", k_active, K_NEW);
      bus_read(ADDR_K, rd);
      check("t3_read_k", rd, 32'd5);
      wait_locked();
      check("t3_k_active_after_lock", k_active, K_NEW);

      // ---- 4: polling mode, write dropped mid-BUSY ----------------------
      bus_write(ADDR_MODE, 32'd1, st);
      bus_write(ADDR_START, 32'd0, st);
      bus_write(ADDR_M, 32'd9, st);
      check("t4_no_stall", st, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (reconfig_done) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      check("t4_done_seen", {31'b0, seen}, 32'd1);
      bus_read(ADDR_STATUS, rd);
      check("t4_status_after_done", rd, 32'd2);
      check("t4_m_active", m_active, 32'd0);
      check("t4_k_active", k_active, 32'd5);
      bus_read(ADDR_M, rd);
      check("t4_m_staged", rd, 32'd0);
      wait_locked();
      bus_read(ADDR_STATUS, rd);
      check("t4_status_idle_err", rd, 32'd3);
      bus_write(ADDR_MODE, 32'd1, st);
      bus_read(ADDR_STATUS, rd);
      check("t4_status_err_clr", rd, 32'd1);
      bus_read(ADDR_MODE, rd);
      check("t4_mode_readback", rd, 32'd1);
      bus_write(ADDR_MODE, 32'd0, st);

      // ---- 5: simultaneous read and write --------------------------------
      bus_read(ADDR_K, rd);
      check("t5_read_k_before", rd, 32'd5);
      bus.mgmt_address   = ADDR_K;
      bus.mgmt_writedata = 32'h1234;
      bus.mgmt_write     = 1'b1;
      bus.mgmt_read      = 1'b1;
      tick();
      bus.mgmt_write = 1'b0;
      bus.mgmt_read  = 1'b0;
      check("t5_readdata_held", bus.mgmt_readdata, 32'd5);
      bus_read(ADDR_K, rd);
      check("t5_read_k_after", rd, 32'h1234);
      bus_read(ADDR_START, rd);
      check("t5_read_start_zero", rd, 32'd0);
      bus_read(6'd3, rd);
      check("t5_read_unmapped", rd, 32'd0);

      // ---- 6: reset in the middle of BUSY --------------------------------
      bus_write(ADDR_START, 32'd0, st);
      for (int i = 0; i < 7; i++) tick();
      check("t6_busy_before_rst", {31'b0, bus.mgmt_waitrequest}, 32'd1);
      #1;
      mgmt_reset = 1'b1;
      #1;
      check("t6_wait_immediate", {31'b0, bus.mgmt_waitrequest}, 32'd0);
      check("t6_k_active_rst",   k_active, K_DEF);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (reconfig_done) seen = 1'b1;
         tick();
         if (i == 1) mgmt_reset = 1'b0;
      end
      check("t6_no_done",      {31'b0, seen}, 32'd0);
      check("t6_relocked",     {31'b0, pll_locked}, 32'd1);
      check("t6_k_active",     k_active, K_DEF);
      bus_read(ADDR_K, rd);
      check("t6_k_staged_def", rd, K_DEF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
